// File: rtl/seg7_pkg.sv
// Shared constants for the two-digit seven-segment count display:
// segment patterns (active-high, bit order {g,f,e,d,c,b,a}) and scan states.
package seg7_pkg;

    localparam logic [6:0] SEG_0   = 7'h3F;
    localparam logic [6:0] SEG_1   = 7'h06;
    localparam logic [6:0] SEG_2   = 7'h5B;
    localparam logic [6:0] SEG_3   = 7'h4F;
    localparam logic [6:0] SEG_4   = 7'h66;
    localparam logic [6:0] SEG_5   = 7'h6D;
    localparam logic [6:0] SEG_6   = 7'h7D;
    localparam logic [6:0] SEG_7   = 7'h07;
    localparam logic [6:0] SEG_8   = 7'h7F;
    localparam logic [6:0] SEG_9   = 7'h6F;
    localparam logic [6:0] SEG_OFF = 7'h00;

    localparam logic [1:0] AN_ONES = 2'b01;
    localparam logic [1:0] AN_TENS = 2'b10;
    localparam logic [1:0] AN_NONE = 2'b00;

    // Which digit the scan FSM is currently driving.
    typedef enum logic {
        DIG_ONES = 1'b0,
        DIG_TENS = 1'b1
    } dig_state_t;

endpackage : seg7_pkg

// File: rtl/seg7_decode.sv
// Combinational BCD digit to seven-segment decoder. Non-decimal inputs
// (10..15) produce a dark digit rather than a misleading glyph.
module seg7_decode
    import seg7_pkg::*;
(
    input  logic [3:0] digit,
    output logic [6:0] seg
);

    // Map one decimal digit to its segment pattern.
    always_comb begin
        seg = SEG_OFF;
        case (digit)
            4'd0:    seg = SEG_0;
            4'd1:    seg = SEG_1;
            4'd2:    seg = SEG_2;
            4'd3:    seg = SEG_3;
            4'd4:    seg = SEG_4;
            4'd5:    seg = SEG_5;
            4'd6:    seg = SEG_6;
            4'd7:    seg = SEG_7;
            4'd8:    seg = SEG_8;
            4'd9:    seg = SEG_9;
            default: seg = SEG_OFF;
        endcase
    end

endmodule : seg7_decode

// File: rtl/seg7_count_display.sv
// Display stage for the 4-bit counter: captures the count on a load strobe,
// splits it into tens/ones and scans both digits of a multiplexed
// seven-segment display. All outputs are registered.
module seg7_count_display
    import seg7_pkg::*;
#(
    parameter int REFRESH_DIV = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] count_in,
    input  logic       load,
    input  logic       blank_lz,
    output logic [6:0] seg,
    output logic [1:0] an,
    output logic       updated
);

    localparam int PW = $clog2(REFRESH_DIV);
    localparam logic [PW-1:0] PRESC_LAST = PW'(REFRESH_DIV - 1);

    logic [3:0]    cap_r;
    logic          updated_r;
    logic [PW-1:0] presc_r;
    logic          tick_s;
    dig_state_t    state_r;
    dig_state_t    state_next_s;
    logic          tens_s;
    logic [3:0]    ones_s;
    logic [3:0]    digit_s;
    logic [6:0]    dec_seg_s;
    logic [6:0]    seg_next_s;
    logic [1:0]    an_next_s;
    logic [6:0]    seg_r;
    logic [1:0]    an_r;

    // Capture register plus change-detect flag, compared against the old value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cap_r     <= 4'd0;
            updated_r <= 1'b0;
        end else begin
            updated_r <= load && (count_in != cap_r);
            if (load) begin
                cap_r <= count_in;
            end else begin
                cap_r <= cap_r;
            end
        end
    end

    assign tick_s = (presc_r == PRESC_LAST);

    // Refresh prescaler: one full wrap is one digit dwell.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            presc_r <= '0;
        end else if (tick_s) begin
            presc_r <= '0;
        end else begin
            presc_r <= presc_r + PW'(1);
        end
    end

    // Scan FSM state register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= DIG_ONES;
        end else begin
            state_r <= state_next_s;
        end
    end

    // Scan FSM next state: alternate digits on every prescaler wrap.
    always_comb begin
        state_next_s = state_r;
        case (state_r)
            DIG_ONES: begin
                if (tick_s) begin
                    state_next_s = DIG_TENS;
                end else begin
                    state_next_s = DIG_ONES;
                end
            end
            DIG_TENS: begin
                if (tick_s) begin
                    state_next_s = DIG_ONES;
                end else begin
                    state_next_s = DIG_TENS;
                end
            end
            default: state_next_s = DIG_ONES;
        endcase
    end

    // Binary to BCD split; the count never exceeds 15 so tens is 0 or 1.
    assign tens_s  = (cap_r >= 4'd10);
    assign ones_s  = tens_s ? (cap_r - 4'd10) : cap_r;
    assign digit_s = (state_r == DIG_TENS) ? {3'b000, tens_s} : ones_s;

    seg7_decode u_decode (
        .digit (digit_s),
        .seg   (dec_seg_s)
    );

    // Scan FSM outputs: digit enable and segments, with optional leading-zero blanking.
    always_comb begin
        seg_next_s = SEG_OFF;
        an_next_s  = AN_NONE;
        case (state_r)
            DIG_ONES: begin
                an_next_s  = AN_ONES;
                seg_next_s = dec_seg_s;
            end
            DIG_TENS: begin
                an_next_s = AN_TENS;
                if (blank_lz && !tens_s) begin
                    seg_next_s = SEG_OFF;
                end else begin
                    seg_next_s = dec_seg_s;
                end
            end
            default: begin
                an_next_s  = AN_NONE;
                seg_next_s = SEG_OFF;
            end
        endcase
    end

    // Output register so the display pins never see decoder glitches.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seg_r <= SEG_OFF;
            an_r  <= AN_NONE;
        end else begin
            seg_r <= seg_next_s;
            an_r  <= an_next_s;
        end
    end

    assign seg     = seg_r;
    assign an      = an_r;
    assign updated = updated_r;

endmodule : seg7_count_display

// File: doc/seg7_count_display.md
# seg7_count_display

Display stage directly downstream of the 4-bit free-running counter: captures the 4-bit count on a load strobe and shows it as a two-digit decimal value (00–15) on a time-multiplexed two-digit seven-segment display. Contains:
- a capture register;
- a binary-to-BCD split;
- a refresh prescaler;
- a two-state digit-scan FSM with registered segment and anode outputs.

## Interface
Parameters:
- REFRESH_DIV, default 4: clock cycles each digit stays enabled. Legal range is 2 or more. Set large on the board, small in simulation.

Ports:
- clk  input  1  system clock; all state updates on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- count_in  input  4  binary count from the counter stage.
- load  input  1  capture strobe; when high at a rising edge, count_in is captured.
- blank_lz  input  1  when high, the tens digit is blanked while it is 0.
- seg  output  7  active-high segments, bit order {g,f,e,d,c,b,a}.
- an  output  2  one-hot, active-high digit enable: an[0] = ones, an[1] = tens.
- updated  output  1  one-cycle pulse when a load changed the captured value.

## Operation
- **Capture register** `cap[3:0]`: `cap <= count_in` on any edge with `load = 1`; otherwise it holds.
- **BCD split**: `tens = (cap >= 10)`; `ones = cap - (tens ? 10 : 0)`. `ones` is 4 bits and is always ≤ 9.
- **Segment encoding**: 0=0x3F, 1=0x06, 2=0x5B, 3=0x4F, 4=0x66, 5=0x6D, 6=0x7D, 7=0x07, 8=0x7F, 9=0x6F.
- **Prescaler**: `$clog2(REFRESH_DIV)` bits. Counts 0..REFRESH_DIV-1, then wraps to 0. `tick = (prescaler == REFRESH_DIV-1)`.
- **FSM states**:
  - DIG_ONES → DIG_TENS on tick.
  - DIG_TENS → DIG_ONES on tick.
  - No other transitions.
- **Output register**, updated every edge from the pre-edge state and `cap`:
  - In DIG_ONES: `an = 01`, `seg = enc(ones)`.
  - In DIG_TENS: `an = 10`, `seg = enc(tens)`.
  - In DIG_TENS with `blank_lz = 1` and `tens = 0`: `seg = 0x00`, `an` remains `10`.
- **updated**: registered `load && (count_in != cap)`, evaluated with the pre-edge value of `cap`.

## Timing
- **Reset** (`rst_n = 0`, asynchronous, takes effect immediately):
  - `cap = 0`, prescaler = 0, state = DIG_ONES.
  - `seg = 0x00`, `an = 00`, `updated = 0`.
- **After reset release**:
  - First edge: `an = 01`, `seg = 0x3F` (ones digit showing 0).
- **Load latency**:
  - `load` at edge k: `cap` is new after edge k, and `updated` is high for the cycle after edge k.
  - `seg` shows the new value from edge k+1, but only for the digit currently selected.
- **Scan timing**:
  - Each digit is enabled for exactly REFRESH_DIV consecutive cycles. `an` is never `11`.
  - `an` changes one edge after the tick edge.
- **Simultaneous events**: `load` and `tick` on the same edge are independent; both take effect.
- **Repeated value**: back-to-back loads of an unchanged value give `updated = 0`.
- **Reset mid-scan**: state and prescaler restart from zero. No partial dwell is carried over.
- **blank_lz**: combinational into the output register. A change is visible after one edge.

## Structure
- **Shared package/header `seg7_pkg`**:
  - SEG_0..SEG_9 and SEG_OFF constants.
  - Digit-state encodings DIG_ONES = 1'b0, DIG_TENS = 1'b1.
- **Sub-module `seg7_decode`**: purely combinational, 4-bit digit in → 7-bit seg out. Values above 9 decode to SEG_OFF. Instantiated once, with its input muxed by the FSM state.
- **Top module**: capture register, prescaler, FSM, output register and updated flag.

## Test plan
All scenarios use REFRESH_DIV = 4.
- **Reset**: `rst_n = 0` mid-clock → `seg = 0x00` and `an = 00` immediately, without waiting for an edge. Release → next edge `an = 01`, `seg = 0x3F`.
- **Scan period**: `count_in = 7`, one load, `blank_lz = 0` → `an` alternates 01/10 every 4 cycles. `seg` is 0x07 under `an = 01` and 0x3F under `an = 10`.
- **Two-digit value and blanking**:
  - Load 13 → `seg` is 0x4F under `an = 01` and 0x06 under `an = 10`.
  - Load 5 with `blank_lz = 1` → `seg` is 0x6D under `an = 01` and 0x00 under `an = 10`.
- **updated pulse**: load 9 → `updated = 1` for one cycle. Load 9 again → `updated = 0`. Load 10 → `updated = 1` and `seg` shows "10" (0x3F ones, 0x06 tens).
- **Counter-driven sweep**: drive `count_in` from the counter with `load = 1` every cycle → `cap` tracks 0..15, then wraps to 0. The display shows each value on the selected digit one edge later.
- **Reset mid-operation**: assert `rst_n = 0` during DIG_TENS dwell cycle 2 → `cap = 0`, `an = 00`. After release, DIG_ONES lasts a full 4 cycles.
